cp0: RTL and testbench

CP0 -- requirements
Module: cp0

---
 rtl/cp0.sv | 55 +++++
 tb/tb_cp0.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cp0.sv
// cp0: MIPS coprocessor-0 register file.
// 32 x 32-bit registers live at select 0 only; selects 1..7 have no storage,
// read as zero and swallow writes. One register (EPC_IDX) also has a
// dedicated capture port for the exception PC, which wins over a general
// write to the same register. Reads are combinational and never bypass a
// write that is still waiting for its clock edge.
module cp0 #(
    parameter int unsigned EPC_IDX = 14
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [4:0]  R_in,
    input  logic [4:0]  W_in,
    input  logic [31:0] Din,
    input  logic [31:0] EPC_in,
    input  logic        WE,
    input  logic        EPC_WE,
    input  logic [2:0]  sel,
    output logic [31:0] R_out,
    output logic [31:0] EPC_out
);

    localparam logic [4:0] EPC_SEL = 5'(EPC_IDX);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    // Next-state of the register file: general write first, EPC capture
    // last so it overrides a general write aimed at the same register.
    always_comb begin
        regs_d = regs_q;
        if (WE && (sel == 3'd0)) begin
            regs_d[W_in] = Din;
        end
        if (EPC_WE) begin
            regs_d[EPC_SEL] = EPC_in;
        end
    end

    // Register file state; clr clears everything and blocks both write ports.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Combinational read: only select 0 is backed by storage.
    assign R_out   = (sel == 3'd0) ? regs_q[R_in] : 32'h0;
    assign EPC_out = regs_q[EPC_SEL];

endmodule

// File: tb/tb_cp0.sv
// Testbench for cp0: directed vector table, hand-written multi-cycle
// sequences (no bypass, synchronous reset, reset priority sweep) and a
// short random run, all compared through an expected-value queue.
module tb_cp0;

  localparam int EPC_IDX = 14;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        clr;
  logic [4:0]  R_in;
  logic [4:0]  W_in;
  logic [31:0] Din;
  logic [31:0] EPC_in;
  logic        WE;
  logic        EPC_WE;
  logic [2:0]  sel;
  logic [31:0] R_out;
  logic [31:0] EPC_out;

  always #5 clk = ~clk;

  cp0 #(.EPC_IDX(EPC_IDX)) dut (
    .clk     (clk),
    .clr     (clr),
    .R_in    (R_in),
    .W_in    (W_in),
    .Din     (Din),
    .EPC_in  (EPC_in),
    .WE      (WE),
    .EPC_WE  (EPC_WE),
    .sel     (sel),
    .R_out   (R_out),
    .EPC_out (EPC_out)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] mdl [32];

  task automatic push_exp(input logic [31:0] r, input logic [31:0] e);
    exp_q.push_back({r, e});
  endtask

  task automatic check_out(input string name);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: expected queue empty", name);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (R_out !== e[63:32]) begin
        errors++;
        $display("FAIL %s R_out: got %h want %h", name, R_out, e[63:32]);
      end
      checks++;
      if (EPC_out !== e[31:0]) begin
        errors++;
        $display("FAIL %s EPC_out: got %h want %h", name, EPC_out, e[31:0]);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Apply one clock edge with the given write-side inputs, then idle them.
  // The reference model follows the block's rules independently.
  task automatic drive(input logic c, input logic we_, input logic epcwe,
                       input logic [2:0] s, input logic [4:0] w,
                       input logic [31:0] d, input logic [31:0] e);
    clr = c; WE = we_; EPC_WE = epcwe; sel = s; W_in = w; Din = d; EPC_in = e;
    @(posedge clk);
    #1;
    if (c) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    end else begin
      if (we_ && s == 3'd0) mdl[w] = d;
      if (epcwe) mdl[EPC_IDX] = e;
    end
    clr = 1'b0; WE = 1'b0; EPC_WE = 1'b0;
  endtask

  task automatic set_read(input logic [4:0] r, input logic [2:0] s);
    R_in = r; sel = s;
    #1;
  endtask

  // Read a register and compare against the reference model.
  task automatic read_model(input string name, input logic [4:0] r);
    set_read(r, 3'd0);
    push_exp(mdl[r], mdl[EPC_IDX]);
    check_out(name);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        c;
    logic        we;
    logic        epcwe;
    logic [2:0]  s;
    logic [4:0]  w;
    logic [31:0] d;
    logic [31:0] e;
    logic [4:0]  r;
    logic [2:0]  rs;
    logic [31:0] exp_r;
    logic [31:0] exp_epc;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 3'd0, 5'd0,  32'h0,         32'h0,         5'd5,  3'd0, 32'h0,         32'h0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 3'd0, 5'd3,  32'h0000_00AB, 32'h0,         5'd3,  3'd0, 32'h0000_00AB, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 3'd0, 5'd0,  32'h0,         32'h0,         5'd3,  3'd1, 32'h0,         32'h0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 3'd2, 5'd7,  32'h0000_1234, 32'h0,         5'd7,  3'd0, 32'h0,         32'h0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 3'd0, 5'd14, 32'h0000_0005, 32'h8000_0180, 5'd14, 3'd0, 32'h8000_0180, 32'h8000_0180};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 3'd0, 5'd0,  32'hDEAD_BEEF, 32'h0,         5'd0,  3'd0, 32'hDEAD_BEEF, 32'h8000_0180};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 3'd5, 5'd0,  32'h0,         32'hBFC0_0000, 5'd14, 3'd0, 32'hBFC0_0000, 32'hBFC0_0000};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 3'd0, 5'd31, 32'h0000_CAFE, 32'h0000_0100, 5'd31, 3'd0, 32'h0000_CAFE, 32'h0000_0100};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 3'd0, 5'd0,  32'h0,         32'h0,         5'd14, 3'd0, 32'h0000_0100, 32'h0000_0100};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 3'd0, 5'd31, 32'h0,         32'h0,         5'd31, 3'd7, 32'h0,         32'h0000_0100};
  end

  // ---------------- test sequence ----------------
  initial begin
    clr = 1'b1; WE = 1'b0; EPC_WE = 1'b0; sel = 3'd0;
    R_in = 5'd0; W_in = 5'd0; Din = 32'h0; EPC_in = 32'h0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    @(posedge clk);
    #1;
    clr = 1'b0;

    // Table-driven directed vectors.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].c, vecs[i].we, vecs[i].epcwe, vecs[i].s, vecs[i].w, vecs[i].d, vecs[i].e);
      set_read(vecs[i].r, vecs[i].rs);
      push_exp(vecs[i].exp_r, vecs[i].exp_epc);
      check_out($sformatf("vec%0d", i));
    end

    // No bypass: same-cycle read of the register being written shows the old value.
    drive(1'b0, 1'b1, 1'b0, 3'd0, 5'd9, 32'h0000_0011, 32'h0);
    clr = 1'b0; WE = 1'b1; EPC_WE = 1'b0; W_in = 5'd9; Din = 32'h0000_0077;
    R_in = 5'd9; sel = 3'd0;
    #1;
    push_exp(32'h0000_0011, 32'h0000_0100);
    check_out("nobypass_before");
    @(posedge clk);
    #1;
    WE = 1'b0;
    push_exp(32'h0000_0077, 32'h0000_0100);
    check_out("nobypass_after");
    mdl[9] = 32'h0000_0077;

    // Full sweep: register i holds i.
    for (int i = 0; i < 32; i++) drive(1'b0, 1'b1, 1'b0, 3'd0, 5'(i), 32'(i), 32'h0);
    for (int i = 0; i < 32; i++) begin
      set_read(5'(i), 3'd0);
      push_exp(32'(i), 32'd14);
      check_out($sformatf("sweep_r%0d", i));
    end

    // Reset priority, and clr raised between edges must not act early.
    clr = 1'b1; WE = 1'b1; EPC_WE = 1'b1; sel = 3'd0; W_in = 5'd5;
    Din = 32'hFFFF_FFFF; EPC_in = 32'h1234_5678; R_in = 5'd5;
    #1;
    push_exp(32'd5, 32'd14);
    check_out("sync_clr_before_edge");
    @(posedge clk);
    #1;
    clr = 1'b0; WE = 1'b0; EPC_WE = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    for (int i = 0; i < 32; i++) begin
      set_read(5'(i), 3'd0);
      push_exp(32'h0, 32'h0);
      check_out($sformatf("clr_prio_r%0d", i));
    end

    // Short random run against the reference model.
    for (int k = 0; k < 40; k++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
            3'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
            $urandom, $urandom);
      read_model($sformatf("rand%0d", k), 5'($urandom_range(0, 31)));
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d left, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
